// File: rtl/ps2_command_sender.sv
// ps2_command_sender
//   Host-to-device PS/2 command transmitter. On a request it inhibits the
//   PS/2 clock, issues a request-to-send, then shifts one byte, odd parity
//   and a stop bit out on the data line, clocked by the device's falling
//   clock edges. Both lines are open-drain: an *_oe of 1 pulls the line low.
//
//   Parameters
//     INHIBIT_CYCLES  clock-inhibit hold time in CLOCK_50 cycles
//     START_TIMEOUT   max cycles to wait for the first device falling edge
//     XFER_TIMEOUT    max cycles from the first falling edge to the ack edge
//
//   Ports
//     CLOCK_50                       system clock, rising edge
//     reset                          asynchronous active-high reset
//     send_command                   one-cycle request strobe (ignored while busy)
//     the_command[7:0]               byte to transmit, sampled on acceptance
//     ps2_clk_in / ps2_dat_in        raw PS/2 line levels
//     ps2_clk_oe / ps2_dat_oe        1 = pull the line low, 0 = release
//     busy                           high whenever the FSM is not idle
//     command_was_sent               one-cycle success pulse
//     error_communication_timed_out  one-cycle failure pulse
//
//   Build option
//     PS2_ACK_CHECK_EN  when defined, the data level at the 11th falling edge
//                       must be low (device ack); a high level takes the
//                       error path. When undefined, edge 11 always succeeds.

module ps2_command_sender #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int START_TIMEOUT  = 750000,
   parameter int XFER_TIMEOUT   = 100000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       send_command,
   input  logic [7:0] the_command,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       command_was_sent,
   output logic       error_communication_timed_out
);

   // One shared cycle counter serves all three timed phases.
   localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > XFER_TIMEOUT) ? CNT_MAX_A : XFER_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] XFER_LAST    = CNT_W'(XFER_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      WAIT_CLK,
      XFER,
      DONE
   } state_t;

   state_t           state, state_next;
   logic [2:0]       clk_sync;            // [1] synchronized level, [2] its previous value
   logic [1:0]       dat_sync;            // [1] synchronized level
   logic             clk_fall;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [3:0]       edge_cnt, edge_next;
   logic [7:0]       data_q, data_next;
   logic             parity_q, parity_next;
   logic             drive_q, drive_next;  // 1 = pull data low for the bit being presented
   logic             err_q, err_next;

   // Synchronizers idle high, matching released open-drain lines.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[1:0], ps2_clk_in};
         dat_sync <= {dat_sync[0], ps2_dat_in};
      end
   end

   assign clk_fall = clk_sync[2] & ~clk_sync[1];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         edge_cnt <= '0;
         data_q   <= '0;
         parity_q <= 1'b0;
         drive_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         edge_cnt <= edge_next;
         data_q   <= data_next;
         parity_q <= parity_next;
         drive_q  <= drive_next;
         err_q    <= err_next;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      state_next  = state;
      cnt_next    = cnt;
      edge_next   = edge_cnt;
      data_next   = data_q;
      parity_next = parity_q;
      drive_next  = drive_q;
      err_next    = 1'b0;

      case (state)
         IDLE: begin
            cnt_next   = '0;
            edge_next  = '0;
            drive_next = 1'b0;
            if (send_command) begin
               data_next   = the_command;
               parity_next = ~^the_command;
               state_next  = INHIBIT;
            end
         end

         INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
               cnt_next   = '0;
               state_next = REQ;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         REQ: begin
            cnt_next   = '0;
            state_next = WAIT_CLK;
         end

         WAIT_CLK: begin
            if (clk_fall) begin
               // The detection cycle counts as the first transfer cycle.
               state_next = XFER;
               edge_next  = 4'd1;
               cnt_next   = CNT_W'(1);
               drive_next = ~data_q[0];
            end else if (cnt == START_LAST) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         XFER: begin
            if (clk_fall && edge_cnt == 4'd10) begin
               edge_next = 4'd11;
`ifdef PS2_ACK_CHECK_EN
               if (dat_sync[1]) begin
                  state_next = IDLE;
                  err_next   = 1'b1;
               end else begin
                  state_next = DONE;
               end
`else
               state_next = DONE;
`endif
            end else begin
               if (clk_fall) begin
                  edge_next = (edge_cnt == 4'd11) ? edge_cnt : edge_cnt + 4'd1;
                  // edge_cnt still holds the previous edge number here.
                  if (edge_cnt <= 4'd7)
                     drive_next = ~data_q[edge_cnt[2:0]];
                  else if (edge_cnt == 4'd8)
                     drive_next = ~parity_q;
                  else
                     drive_next = 1'b0;      // stop bit: release the line
               end
               // Timeout is checked on edge cycles too so it can never be skipped.
               if (cnt == XFER_LAST) begin
                  state_next = IDLE;
                  err_next   = 1'b1;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end

         DONE: state_next = IDLE;

         default: state_next = IDLE;
      endcase
   end

`ifndef PS2_ACK_CHECK_EN
   // The synchronized data level is only consulted when ack checking is built in.
   logic ack_level_unused;
   assign ack_level_unused = dat_sync[1];
`endif

   assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
   assign ps2_dat_oe = (state == REQ) || (state == WAIT_CLK) || ((state == XFER) && drive_q);
   assign busy       = (state != IDLE);
   assign command_was_sent              = (state == DONE);
   assign error_communication_timed_out = err_q;

endmodule

// File: tb/tb_ps2_command_sender.sv
// tb_ps2_command_sender
//   Directed bench for ps2_command_sender with scaled-down timing parameters
//   and a simple open-drain PS/2 device model. Define PS2_ACK_CHECK_EN for
//   both bench and RTL to exercise the ack-checking build.

module tb_ps2_command_sender;

   localparam int INH   = 40;
   localparam int START = 300;
   localparam int XFER  = 600;
   localparam int HALF  = 20;    // device clock half-period in system cycles

   logic       clk = 1'b0;
   logic       reset;
   logic       send_command;
   logic [7:0] the_command;
   logic       ps2_clk_in, ps2_dat_in;
   logic       ps2_clk_oe, ps2_dat_oe;
   logic       busy, command_was_sent, error_communication_timed_out;

   logic dev_clk_low = 1'b0;
   logic dev_dat_low = 1'b0;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int sent_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;

   // Open-drain lines: low if either side pulls.
   assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

   ps2_command_sender #(
      .INHIBIT_CYCLES(INH),
      .START_TIMEOUT (START),
      .XFER_TIMEOUT  (XFER)
   ) dut (
      .CLOCK_50                     (clk),
      .reset                        (reset),
      .send_command                 (send_command),
      .the_command                  (the_command),
      .ps2_clk_in                   (ps2_clk_in),
      .ps2_dat_in                   (ps2_dat_in),
      .ps2_clk_oe                   (ps2_clk_oe),
      .ps2_dat_oe                   (ps2_dat_oe),
      .busy                         (busy),
      .command_was_sent             (command_was_sent),
      .error_communication_timed_out(error_communication_timed_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (command_was_sent) sent_cnt++;
      if (error_communication_timed_out) err_cnt++;
      if (command_was_sent && error_communication_timed_out) both_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the first negedge after acceptance.
   task automatic send(input logic [7:0] b);
      the_command  = b;
      send_command = 1'b1;
      @(negedge clk);
      send_command = 1'b0;
      the_command  = 8'h00;
   endtask

   // Device side of one frame. frame[0] = start, [8:1] = data, [9] = parity,
   // [10] = stop, each as seen on the line mid-low-phase after its edge.
   task automatic device_frame(input int n_edges, input logic ack_low, input int poke_edge,
                               input int reset_edge, output logic [10:0] frame, output int fall1);
      int t;
      frame = '0;
      fall1 = 0;
      t = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("rts_seen", 32'(t < 2000), 32'd1);
      if (t >= 2000) return;
      repeat (5) @(negedge clk);
      frame[0] = ps2_dat_in;
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 11 && ack_low) dev_dat_low = 1'b1;
         dev_clk_low = 1'b1;
         if (k == 1) fall1 = cyc;
         if (k == reset_edge) begin
            #1 reset = 1'b1;
            #1;
            check("rst_async_clk_oe", ps2_clk_oe, 0);
            check("rst_async_dat_oe", ps2_dat_oe, 0);
            check("rst_async_busy", busy, 0);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            return;
         end
         if (k == poke_edge) begin
            the_command  = 8'h00;
            send_command = 1'b1;
            @(negedge clk);
            send_command = 1'b0;
            repeat (HALF - 1) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         if (k <= 10) begin
            frame[k] = ps2_dat_in;
            check("busy_in_xfer", busy, 1);
         end
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge clk);
      end
      dev_dat_low = 1'b0;
   endtask

   initial begin
      logic [10:0] frame;
      int f1, s0, e0;

      reset        = 1'b1;
      send_command = 1'b0;
      the_command  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_dat_oe", ps2_dat_oe, 0);
      check("rst_busy", busy, 0);
      check("rst_sent", command_was_sent, 0);
      check("rst_err", error_communication_timed_out, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);

      // 0xED: line bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1
      s0 = sent_cnt; e0 = err_cnt;
      send(8'hED);
      check("ed_busy_accept", busy, 1);
      check("ed_inhibit_clk", ps2_clk_oe, 1);
      check("ed_inhibit_dat", ps2_dat_oe, 0);
      device_frame(11, 1'b1, 0, 0, frame, f1);
      check("ed_frame", frame, 11'b1_1_11101101_0);
      repeat (10) @(negedge clk);
      check("ed_sent", sent_cnt - s0, 1);
      check("ed_no_err", err_cnt - e0, 0);
      check("ed_busy_after", busy, 0);
      check("ed_dat_released", ps2_dat_oe, 0);

      // 0xF4: parity 0
      s0 = sent_cnt;
      send(8'hF4);
      device_frame(11, 1'b1, 0, 0, frame, f1);
      check("f4_frame", frame, 11'b1_0_11110100_0);
      repeat (10) @(negedge clk);
      check("f4_sent", sent_cnt - s0, 1);

      // 0xFF: parity 1
      s0 = sent_cnt;
      send(8'hFF);
      device_frame(11, 1'b1, 0, 0, frame, f1);
      check("ff_frame", frame, 11'b1_1_11111111_0);
      repeat (10) @(negedge clk);
      check("ff_sent", sent_cnt - s0, 1);

      // No device clock: INH cycles inhibit, 1 cycle REQ, START cycles wait, then error.
      s0 = sent_cnt; e0 = err_cnt;
      send(8'h5A);
      repeat (INH - 1) @(negedge clk);
      check("nc_inhibit_last_clk", ps2_clk_oe, 1);
      check("nc_inhibit_last_dat", ps2_dat_oe, 0);
      @(negedge clk);
      check("nc_req_clk", ps2_clk_oe, 1);
      check("nc_req_dat", ps2_dat_oe, 1);
      @(negedge clk);
      check("nc_wait_clk", ps2_clk_oe, 0);
      check("nc_wait_dat", ps2_dat_oe, 1);
      repeat (START - 1) @(negedge clk);
      check("nc_err_not_yet", error_communication_timed_out, 0);
      check("nc_still_start", ps2_dat_oe, 1);
      @(negedge clk);
      check("nc_err_pulse", error_communication_timed_out, 1);
      check("nc_clk_released", ps2_clk_oe, 0);
      check("nc_dat_released", ps2_dat_oe, 0);
      check("nc_busy", busy, 0);
      @(negedge clk);
      check("nc_err_one_cycle", error_communication_timed_out, 0);
      check("nc_no_sent", sent_cnt - s0, 0);

      // Device stops after edge 5; a second request at edge 3 is ignored.
      // The synchronizer makes edge 1 visible two clocks after the line falls,
      // so the error lands XFER clocks after that.
      s0 = sent_cnt; e0 = err_cnt;
      send(8'hA5);
      device_frame(5, 1'b0, 3, 0, frame, f1);
      check("st_partial_frame", frame, 11'h00A);
      while (cyc < f1 + 1 + XFER) @(negedge clk);
      check("st_err_not_yet", error_communication_timed_out, 0);
      @(negedge clk);
      check("st_err_pulse", error_communication_timed_out, 1);
      check("st_clk_released", ps2_clk_oe, 0);
      check("st_dat_released", ps2_dat_oe, 0);
      repeat (5) @(negedge clk);
      check("st_err_count", err_cnt - e0, 1);
      check("st_no_sent", sent_cnt - s0, 0);
      check("st_poke_ignored", busy, 0);

      // Reset at edge 6, then a fresh 0xFF transfer.
      s0 = sent_cnt; e0 = err_cnt;
      send(8'h3C);
      device_frame(11, 1'b1, 0, 6, frame, f1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rs_idle_busy", busy, 0);
      check("rs_no_pulses", (sent_cnt - s0) + (err_cnt - e0), 0);
      send(8'hFF);
      check("rs_fresh_inhibit", ps2_clk_oe, 1);
      device_frame(11, 1'b1, 0, 0, frame, f1);
      check("rs_ff_frame", frame, 11'b1_1_11111111_0);
      repeat (10) @(negedge clk);
      check("rs_ff_sent", sent_cnt - s0, 1);

      // Device leaves data high at edge 11 (0x96: parity 1).
      s0 = sent_cnt; e0 = err_cnt;
      send(8'h96);
      device_frame(11, 1'b0, 0, 0, frame, f1);
      check("na_frame", frame, 11'b1_1_10010110_0);
      repeat (10) @(negedge clk);
`ifdef PS2_ACK_CHECK_EN
      check("na_err", err_cnt - e0, 1);
      check("na_no_sent", sent_cnt - s0, 0);
`else
      check("na_sent", sent_cnt - s0, 1);
      check("na_no_err", err_cnt - e0, 0);
`endif
      check("na_busy", busy, 0);

      check("pulses_exclusive", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
